tick_prescaler: RTL and testbench
=================================

# tick_prescaler

Programmable enable-strobe generator sitting directly upstream of the 4-bit event counter. It takes a divide ratio through a valid/ready config handshake and, once started, emits a single-cycle `tick` every `cfg_div+1` cycles. `tick` wires straight to the counter's `en`. It supports periodic and one-shot modes, so the counter advances at a controlled rate rather than every cycle.

## Interface
- `DIV_W`, default 8: width of the divide-ratio field and phase counter.
- `clk`  in  1  single clock, rising edge.
- `rst_aL`  in  1  reset, synchronous, active-low.
- `cfg_valid`  in  1  config offer.
- `cfg_ready`  out  1  config accepted this cycle when high together with `cfg_valid`.
- `cfg_div`  in  DIV_W  tick period minus one.
- `cfg_oneshot`  in  1  1 = emit one tick then stop; 0 = periodic.
- `start`  in  1  level-sampled start request.
- `stop`  in  1  level-sampled stop request.
- `tick`  out  1  single-cycle strobe; drives downstream counter `en`.
- `busy`  out  1  high while in RUN.
- `tick_total`  out  16  saturating count of emitted ticks (only with `TICK_PRESCALER_STATS_EN`).

## Operation
- Registered state: `state`, `phase[DIV_W-1:0]`, `div_q`, `oneshot_q`.
- State IDLE: no valid config.
  - `cfg_ready`=1.
  - Handshake → load `div_q`/`oneshot_q`, go to ARMED.
  - `start` ignored.
- State ARMED:
  - `cfg_ready`=1; a handshake reloads `div_q`/`oneshot_q` and stays ARMED.
  - `start`=1 and `stop`=0 → RUN, `phase`←0.
  - `start`=1 and `stop`=1 → stay ARMED (stop wins).
  - Handshake together with `start`: the new config is loaded and RUN begins using the new config.
- State RUN:
  - `cfg_ready`=0, `busy`=1.
  - `phase` increments each cycle.
  - `tick` = (state==RUN && phase==div_q), combinational from registers.
  - On the tick cycle, `phase` wraps to 0.
  - If `oneshot_q`=1, the tick cycle transitions to ARMED.
- `stop` in RUN → ARMED, `phase`←0.
  - `tick` is still asserted if that cycle is a tick cycle; the counter sees it.
- `cfg_div`=0 → `tick` high every RUN cycle (periodic) or exactly one cycle (one-shot).
- `cfg_div`=2^DIV_W−1 → period 2^DIV_W. `phase` never exceeds `div_q`, so no overflow.
- `start` while already in RUN is ignored; no phase restart.

## Timing
- Reset (`rst_aL` low at a rising edge) forces the following, taking priority over all inputs, including mid-RUN:
  - state=IDLE, phase=0, div_q=0, oneshot_q=0.
  - tick=0, busy=0, cfg_ready=1, tick_total=0.
- Config load latency: 1 edge. State is ARMED in the cycle after the handshake.
- Let the edge sampling `start` be E0. RUN begins after E0, with cycle 1 being the first RUN cycle.
  - First `tick` is high in RUN cycle `div+1`.
  - Subsequent ticks follow every `div+1` cycles.
- `busy` rises the cycle after E0 and falls the cycle after a stop or one-shot tick edge.
- `tick` is never high for two consecutive cycles unless `div_q`=0.

## Configuration
- Macro: `TICK_PRESCALER_STATS_EN`.
- Defined:
  - `tick_total` port exists.
  - It increments on every `tick` cycle and saturates at 16'hFFFF.
  - It is cleared by reset and by any accepted config handshake.
- Undefined: the port and its register are absent. All other behaviour is identical.

## Structure
- Package `tick_prescaler_pkg` holds:
  - state enum `tp_state_e` {TP_IDLE, TP_ARMED, TP_RUN};
  - `TP_STATS_W`=16;
  - `TP_STATS_MAX`=16'hFFFF.
- One sub-module, `tick_phase_ctr`: DIV_W-bit phase counter with synchronous clear, enable, and a `hit` output (`phase==limit`).
- The FSM, config registers and stats stay in the top module.

## Test plan
- Reset, then hold `rst_aL` high with no config. Required: `tick`=0, `busy`=0, `cfg_ready`=1; `start` pulses are ignored and the state stays IDLE.
- Load `cfg_div`=3, `oneshot`=0, then pulse `start`. Required:
  - `tick` high in RUN cycles 4, 8, 12;
  - downstream counter reads 1, 2, 3 after those ticks.
- Load `cfg_div`=2, `oneshot`=1, then `start`. Required: one `tick` in RUN cycle 3, `busy` falls the next cycle, and no further ticks over 10 cycles.
- In RUN with `cfg_div`=4, assert `stop` on a tick cycle. Required: that tick is seen, the state becomes ARMED, and `cfg_ready`=1 the next cycle. Separately, `start`+`stop` together in ARMED → stays ARMED.
- `cfg_div`=0 periodic. Required: `tick` high every RUN cycle. Also drop `rst_aL` mid-RUN → next cycle all outputs are at reset values.
- With `TICK_PRESCALER_STATS_EN`, `cfg_div`=0 for 70000 cycles. Required: `tick_total` saturates at 65535; a new config handshake clears it to 0.

Source files
------------

// File: rtl/tick_prescaler_pkg.sv
// Shared types and constants for the tick prescaler slice.
package tick_prescaler_pkg;

    typedef enum logic [1:0] {
        TP_IDLE,
        TP_ARMED,
        TP_RUN
    } tp_state_e;

    localparam int unsigned              TP_STATS_W   = 16;
    localparam logic [TP_STATS_W-1:0]    TP_STATS_MAX = 16'hFFFF;

endpackage

// File: rtl/tick_phase_ctr.sv
// Phase counter for the prescaler: synchronous clear, count enable and a
// compare output that flags phase == limit.
module tick_phase_ctr #(
    parameter int unsigned DIV_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_aL_i,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [DIV_W-1:0] limit_i,
    output logic             hit_o
);

    logic [DIV_W-1:0] phase_q;

    // Phase register: reset and clear both return to zero, clear beats enable.
    always_ff @(posedge clk_i) begin
        if (!rst_aL_i || clr_i) begin
            phase_q <= '0;
        end else if (en_i) begin
            phase_q <= phase_q + 1'b1;
        end
    end

    assign hit_o = (phase_q == limit_i);

endmodule

// File: rtl/tick_prescaler.sv
// Programmable enable-strobe generator feeding the downstream event counter.
// Optional tick statistics are built when TICK_PRESCALER_STATS_EN is defined.
module tick_prescaler
    import tick_prescaler_pkg::*;
#(
    parameter int unsigned DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst_aL,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic             cfg_oneshot,
    input  logic             start,
    input  logic             stop,
    output logic             tick,
    output logic             busy
`ifdef TICK_PRESCALER_STATS_EN
    ,
    output logic [TP_STATS_W-1:0] tick_total
`endif
);

    tp_state_e        state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             oneshot_q, oneshot_d;
    logic             hit;
    logic             hs;
    logic             in_run;
    logic             phase_clr;

    assign in_run    = (state_q == TP_RUN);
    assign cfg_ready = !in_run;
    assign busy      = in_run;
    assign hs        = cfg_valid && cfg_ready;
    assign tick      = in_run && hit;
    // Phase sits at zero outside RUN and wraps on a tick or a stop, so it
    // never passes div_q and a full-range divide cannot overflow.
    assign phase_clr = !in_run || tick || stop;

    tick_phase_ctr #(
        .DIV_W (DIV_W)
    ) u_phase (
        .clk_i    (clk),
        .rst_aL_i (rst_aL),
        .clr_i    (phase_clr),
        .en_i     (in_run),
        .limit_i  (div_q),
        .hit_o    (hit)
    );

    // State and configuration registers.
    always_ff @(posedge clk) begin
        if (!rst_aL) begin
            state_q   <= TP_IDLE;
            div_q     <= '0;
            oneshot_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            oneshot_q <= oneshot_d;
        end
    end

    // Next-state and config-load logic.
    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        oneshot_d = oneshot_q;
        unique case (state_q)
            TP_IDLE: begin
                if (hs) begin
                    div_d     = cfg_div;
                    oneshot_d = cfg_oneshot;
                    state_d   = TP_ARMED;
                end
            end
            TP_ARMED: begin
                if (hs) begin
                    div_d     = cfg_div;
                    oneshot_d = cfg_oneshot;
                end
                if (start && !stop) begin
                    state_d = TP_RUN;
                end
            end
            TP_RUN: begin
                if (stop || (tick && oneshot_q)) begin
                    state_d = TP_ARMED;
                end
            end
            default: state_d = TP_IDLE;
        endcase
    end

`ifdef TICK_PRESCALER_STATS_EN
    logic [TP_STATS_W-1:0] total_q;

    // Saturating tick count, cleared by reset and by every accepted config.
    always_ff @(posedge clk) begin
        if (!rst_aL || hs) begin
            total_q <= '0;
        end else if (tick && (total_q != TP_STATS_MAX)) begin
            total_q <= total_q + 1'b1;
        end
    end

    assign tick_total = total_q;
`endif

endmodule

// File: tb/tb_tick_prescaler.sv
// Self-checking bench for tick_prescaler with a run-cycle arithmetic model.
module tb_tick_prescaler;

    localparam int DIV_W = 8;
    localparam int M_IDLE  = 0;
    localparam int M_ARMED = 1;
    localparam int M_RUN   = 2;

    logic             clk = 1'b0;
    logic             rst_aL = 1'b0;
    logic             cfg_valid = 1'b0;
    logic             cfg_ready;
    logic [DIV_W-1:0] cfg_div = '0;
    logic             cfg_oneshot = 1'b0;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic             tick;
    logic             busy;
    logic [15:0]      tick_total;

    int checks = 0;
    int errors = 0;

    tick_prescaler #(
        .DIV_W (DIV_W)
    ) dut (
        .clk         (clk),
        .rst_aL      (rst_aL),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_div     (cfg_div),
        .cfg_oneshot (cfg_oneshot),
        .start       (start),
        .stop        (stop),
        .tick        (tick),
        .busy        (busy)
`ifdef TICK_PRESCALER_STATS_EN
        ,
        .tick_total  (tick_total)
`endif
    );

`ifndef TICK_PRESCALER_STATS_EN
    assign tick_total = '0;
`endif

    always #5 clk = ~clk;

    // Reference model: mode, 1-based RUN cycle number n, loaded config.
    int m_mode = M_IDLE;
    int m_n = 0;
    int m_div = 0;
    int m_os = 0;
    int m_total = 0;
    int m_dcnt = 0;
    logic [3:0] dcnt = '0;

    function automatic bit m_tick();
        return (m_mode == M_RUN) && ((m_n % (m_div + 1)) == 0);
    endfunction

    always @(posedge clk) begin
        if (!rst_aL) begin
            m_mode = M_IDLE; m_n = 0; m_div = 0; m_os = 0; m_total = 0;
        end else begin
            case (m_mode)
                M_IDLE: if (cfg_valid) begin
                    m_div = cfg_div; m_os = cfg_oneshot; m_total = 0; m_mode = M_ARMED;
                end
                M_ARMED: begin
                    if (cfg_valid) begin
                        m_div = cfg_div; m_os = cfg_oneshot; m_total = 0;
                    end
                    if (start && !stop) begin
                        m_mode = M_RUN; m_n = 1;
                    end
                end
                default: begin
                    if (m_tick()) begin
                        m_dcnt = (m_dcnt + 1) % 16;
                        if (m_total < 65535) m_total = m_total + 1;
                    end
                    if (stop || (m_tick() && m_os != 0)) begin
                        m_mode = M_ARMED; m_n = 0;
                    end else begin
                        m_n = m_n + 1;
                    end
                end
            endcase
        end
    end

    // Downstream 4-bit event counter enabled by the DUT tick.
    always @(posedge clk) begin
        if (tick === 1'b1) dcnt <= dcnt + 4'd1;
    end

    task automatic load(input int div, input bit os);
        cfg_div = DIV_W'(div); cfg_oneshot = os; cfg_valid = 1'b1;
        @(posedge clk); #1;
        cfg_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_aL = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (tick !== 1'b0 || busy !== 1'b0 || cfg_ready !== 1'b1 || tick_total !== 16'd0) begin
            errors++;
            $display("FAIL reset_values tick=%b busy=%b ready=%b total=%0d want 0 0 1 0", tick, busy, cfg_ready, tick_total);
        end
        @(posedge clk); #1;
        rst_aL = 1'b1;
        for (int i = 0; i < 6; i++) begin
            start = i[0];
            @(negedge clk);
            checks++;
            if (tick !== 1'b0 || busy !== 1'b0 || cfg_ready !== 1'b1) begin
                errors++;
                $display("FAIL idle_start_ignored cyc=%0d tick=%b busy=%b ready=%b want 0 0 1", i, tick, busy, cfg_ready);
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
    endtask

    task automatic test_periodic();
        load(3, 1'b0);
        m_dcnt = 0; dcnt = '0;
        pulse_start();
        for (int i = 1; i <= 13; i++) begin
            @(negedge clk);
            checks++;
            if (tick !== m_tick() || tick !== ((i % 4) == 0)) begin
                errors++;
                $display("FAIL periodic_tick runcyc=%0d tick=%b want %b", i, tick, (i % 4) == 0);
            end
            if (i == 13) begin
                checks++;
                if (dcnt !== 4'd3 || int'(dcnt) != m_dcnt) begin
                    errors++;
                    $display("FAIL periodic_counter got %0d want 3", dcnt);
                end
            end
            @(posedge clk); #1;
        end
        stop = 1'b1; @(posedge clk); #1; stop = 1'b0;
    endtask

    task automatic test_oneshot();
        int tick_at = -1;
        int ticks = 0;
        load(2, 1'b1);
        pulse_start();
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            checks++;
            if (tick !== m_tick() || busy !== (m_mode == M_RUN)) begin
                errors++;
                $display("FAIL oneshot_cycle runcyc=%0d tick=%b busy=%b want %b %b", i, tick, busy, m_tick(), m_mode == M_RUN);
            end
            if (tick === 1'b1) begin ticks++; tick_at = i; end
            if (i == 4) begin
                checks++;
                if (busy !== 1'b0) begin
                    errors++;
                    $display("FAIL oneshot_busy_fall busy=%b want 0", busy);
                end
            end
            @(posedge clk); #1;
        end
        checks++;
        if (ticks != 1 || tick_at != 3) begin
            errors++;
            $display("FAIL oneshot_count ticks=%0d at=%0d want 1 at 3", ticks, tick_at);
        end
    endtask

    task automatic test_stop_on_tick();
        bit found = 0;
        load(4, 1'b0);
        pulse_start();
        for (int i = 1; i <= 20 && !found; i++) begin
            @(negedge clk);
            if (m_tick()) begin
                found = 1;
                stop = 1'b1;
                checks++;
                if (tick !== 1'b1 || i != 5) begin
                    errors++;
                    $display("FAIL stop_tick_seen runcyc=%0d tick=%b want 1 at 5", i, tick);
                end
            end
            @(posedge clk); #1;
        end
        stop = 1'b0;
        if (!found) begin
            checks++; errors++;
            $display("FAIL stop_tick_timeout no tick in 20 cycles");
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || cfg_ready !== 1'b1 || tick !== 1'b0) begin
            errors++;
            $display("FAIL stop_to_armed busy=%b ready=%b tick=%b want 0 1 0", busy, cfg_ready, tick);
        end
        @(posedge clk); #1;
        start = 1'b1; stop = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; stop = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || cfg_ready !== 1'b1) begin
                errors++;
                $display("FAIL start_stop_armed busy=%b ready=%b want 0 1", busy, cfg_ready);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_div0_and_reset();
        load(0, 1'b0);
        pulse_start();
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            checks++;
            if (tick !== 1'b1 || busy !== 1'b1) begin
                errors++;
                $display("FAIL div0_tick runcyc=%0d tick=%b busy=%b want 1 1", i, tick, busy);
            end
            @(posedge clk); #1;
        end
        rst_aL = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (tick !== 1'b0 || busy !== 1'b0 || cfg_ready !== 1'b1 || tick_total !== 16'd0) begin
            errors++;
            $display("FAIL midrun_reset tick=%b busy=%b ready=%b total=%0d want 0 0 1 0", tick, busy, cfg_ready, tick_total);
        end
        rst_aL = 1'b1;
        @(posedge clk); #1;
        pulse_start();
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_drops_config busy=%b want 0", busy);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_max_div();
        int first = -1;
        load(255, 1'b0);
        pulse_start();
        for (int i = 1; i <= 520; i++) begin
            @(negedge clk);
            if (tick === 1'b1 && first < 0) first = i;
            if (tick !== m_tick()) begin
                checks++; errors++;
                $display("FAIL maxdiv_tick runcyc=%0d tick=%b want %b", i, tick, m_tick());
            end
            @(posedge clk); #1;
        end
        checks++;
        if (first != 256) begin
            errors++;
            $display("FAIL maxdiv_first got %0d want 256", first);
        end
        stop = 1'b1; @(posedge clk); #1; stop = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            cfg_valid   = ($urandom_range(0, 7) == 0);
            cfg_div     = DIV_W'($urandom_range(0, 6));
            cfg_oneshot = $urandom_range(0, 1);
            start       = ($urandom_range(0, 3) == 0);
            stop        = ($urandom_range(0, 19) == 0);
            rst_aL      = ($urandom_range(0, 199) != 0);
            @(negedge clk);
            checks++;
            if (tick !== m_tick() || busy !== (m_mode == M_RUN) || cfg_ready !== (m_mode != M_RUN)
`ifdef TICK_PRESCALER_STATS_EN
                || int'(tick_total) != m_total
`endif
               ) begin
                errors++;
                $display("FAIL random cyc=%0d tick=%b busy=%b ready=%b total=%0d want %b %b %b %0d",
                         i, tick, busy, cfg_ready, tick_total, m_tick(), m_mode == M_RUN, m_mode != M_RUN, m_total);
            end
            @(posedge clk); #1;
        end
        cfg_valid = 1'b0; start = 1'b0; stop = 1'b1; rst_aL = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
    endtask

`ifdef TICK_PRESCALER_STATS_EN
    task automatic test_stats();
        load(0, 1'b0);
        pulse_start();
        repeat (70000) @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (tick_total !== 16'hFFFF || int'(tick_total) != m_total) begin
            errors++;
            $display("FAIL stats_saturate got %0d want 65535", tick_total);
        end
        stop = 1'b1; @(posedge clk); #1; stop = 1'b0;
        load(5, 1'b0);
        @(negedge clk);
        checks++;
        if (tick_total !== 16'd0) begin
            errors++;
            $display("FAIL stats_clear got %0d want 0", tick_total);
        end
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        test_reset();
        test_periodic();
        test_oneshot();
        test_stop_on_tick();
        test_div0_and_reset();
        test_max_div();
        test_random();
`ifdef TICK_PRESCALER_STATS_EN
        test_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
